// File: rtl/fp_normalizer.sv
// fp_normalizer: two-stage post-add normalization for the single-precision adder.
// Stage 1 decides shift/exponent/class from (in_exp, in_lzc, in_mant); stage 2 applies
// the left shift and presents the result. Valid/ready handshake on both sides.
// Optional build macro FP_NORM_LZC_CHECK_EN adds a sticky cross-check of in_lzc.
module fp_normalizer #(
  parameter int unsigned L  = 23,
  parameter int unsigned EW = 8,
  parameter int unsigned CW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [L:0]    in_mant,
  input  logic [CW-1:0] in_lzc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [L-1:0]  out_frac,
  output logic          out_zero,
  output logic          out_denorm,
  output logic          lzc_err
);

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [L:0]    mant;
    logic [CW-1:0] shift;
    logic          zero;
    logic          denorm;
  } s1_t;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [L-1:0]  frac;
    logic          zero;
    logic          denorm;
  } s2_t;

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  s1_t         s1_q, s1_d, dec;
  s2_t         s2_q, s2_d;
  logic        s1_adv, s2_adv;
  logic [EW:0] exp_ext, lzc_ext;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // One extra bit so the compare/subtract can never wrap.
  assign exp_ext = {1'b0, in_exp};
  assign lzc_ext = (EW+1)'(in_lzc);

  // Classify the incoming beat and pick the shift amount and resulting exponent.
  always_comb begin
    dec      = '0;
    dec.sign = in_sign;
    dec.mant = in_mant;
    if (in_mant == '0) begin
      dec.zero = 1'b1;
    end else if (exp_ext > lzc_ext) begin
      dec.shift = in_lzc;
      dec.exp   = EW'(exp_ext - lzc_ext);
    end else if (in_exp != '0) begin
      // Exponent cannot absorb the full shift: stop at exp 1, encode as denormal.
      dec.shift  = CW'(in_exp - EW'(1));
      dec.denorm = 1'b1;
    end else begin
      dec.denorm = 1'b1;
    end
  end

  // Pipeline advance: each stage loads when it is empty or its consumer drains it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.sign   = s1_q.sign;
        s2_d.exp    = s1_q.exp;
        // Hidden bit (shifted[L]) and anything above it are dropped here.
        s2_d.frac   = L'(s1_q.mant << s1_q.shift);
        s2_d.zero   = s1_q.zero;
        s2_d.denorm = s1_q.denorm;
      end
    end
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = dec;
      end
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_sign   = s2_q.sign;
  assign out_exp    = s2_q.exp;
  assign out_frac   = s2_q.frac;
  assign out_zero   = s2_q.zero;
  assign out_denorm = s2_q.denorm;

`ifdef FP_NORM_LZC_CHECK_EN
  logic [CW-1:0] true_lzc;
  logic          lzc_err_q, lzc_err_d;

  // Reference leading-zero count; the highest set bit wins. Zero mantissa counts as 0.
  always_comb begin
    true_lzc = '0;
    for (int i = 0; i <= int'(L); i++) begin
      if (in_mant[i]) begin
        true_lzc = CW'(int'(L) - i);
      end
    end
  end

  // Sticky mismatch flag, sampled only on accepted beats.
  always_comb begin
    lzc_err_d = lzc_err_q;
    if (in_valid && in_ready && (true_lzc != in_lzc)) begin
      lzc_err_d = 1'b1;
    end
  end

  // Mismatch flag register; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzc_err_q <= 1'b0;
    end else begin
      lzc_err_q <= lzc_err_d;
    end
  end

  assign lzc_err = lzc_err_q;
`else
  assign lzc_err = 1'b0;
`endif

endmodule
